// File: rtl/queue_ctrl_param.sv
// queue_ctrl_param: pointer/handshake controller for a 1R1W register-file queue; QUEUE_CTRL_ALMOST_FULL_EN enables out_almost_full
module queue_ctrl_param #(
  parameter int BITS = 2,
  parameter int SIZE = 4,
  parameter int WIDTH = 32,
  parameter int AFULL_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_push_valid,
  input  logic [WIDTH-1:0] in_push_data,
  output logic             out_push_ready,
  output logic             out_pop_valid,
  output logic [WIDTH-1:0] out_pop_data,
  input  logic             in_pop_ready,
  output logic             out_wr_en,
  output logic [BITS-1:0]  out_wr_addr,
  output logic [WIDTH-1:0] out_wr_data,
  output logic [BITS-1:0]  out_rd_addr,
  input  logic [WIDTH-1:0] in_rd_data,
  output logic [BITS:0]    out_count,
  output logic             out_empty,
  output logic             out_full,
  output logic             out_almost_full
);
  localparam logic [BITS-1:0] LAST = BITS'(SIZE - 1);
  localparam logic [BITS:0] FULL_CNT = (BITS + 1)'(SIZE);
  logic [BITS-1:0] wr_ptr, rd_ptr;
  logic [BITS:0] count;
  logic push, pop;
  assign out_empty = count == '0;
  assign out_full = count == FULL_CNT;
  assign out_push_ready = !out_full;
  assign out_pop_valid = !out_empty;
  assign push = in_push_valid & out_push_ready;
  assign pop = out_pop_valid & in_pop_ready;
  assign out_wr_en = push;
  assign out_wr_addr = wr_ptr;
  assign out_wr_data = in_push_data;
  assign out_rd_addr = rd_ptr;
  assign out_pop_data = in_rd_data;
  assign out_count = count;
`ifdef QUEUE_CTRL_ALMOST_FULL_EN
  assign out_almost_full = count >= (BITS + 1)'(AFULL_THRESH);
`else
  assign out_almost_full = 1'b0;
`endif
  // Explicit wrap at SIZE-1 keeps non-power-of-two depths in range
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
  end
endmodule
